// File: rtl/subbytes_seq_if.sv
// Handshake bundle around the SubBytes sequencer: byte input stream,
// request/acknowledge link to the external S-box core, and byte output stream.
interface subbytes_seq_if;
    // Input byte stream (two shares when masked).
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_mask;

    // Link to the external S-box core.
    logic       sbox_req;
    logic [7:0] sbox_data;
    logic [7:0] sbox_mask_in;
    logic [7:0] sbox_mask_out;
    logic       sbox_ack;
    logic [7:0] sbox_res;

    // Output byte stream (two shares when masked).
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_mask;

    // Block in flight.
    logic       busy;

    // Sequencer side.
    modport master (
        input  in_valid, in_data, in_mask,
        input  sbox_ack, sbox_res,
        input  out_ready,
        output in_ready,
        output sbox_req, sbox_data, sbox_mask_in, sbox_mask_out,
        output out_valid, out_data, out_mask,
        output busy
    );

    // Environment side: producer, S-box core and consumer.
    modport slave (
        output in_valid, in_data, in_mask,
        output sbox_ack, sbox_res,
        output out_ready,
        input  in_ready,
        input  sbox_req, sbox_data, sbox_mask_in, sbox_mask_out,
        input  out_valid, out_data, out_mask,
        input  busy
    );
endinterface

// File: rtl/subbytes_seq.sv
// SubBytes sequencer: loads a block of NBYTES (optionally Boolean-masked)
// bytes, feeds them one at a time to an external S-box core with a fresh
// output mask from an 8-bit Galois LFSR, then streams the results out in
// input order. Data and mask shares are only ever moved, never combined,
// so the unmasked value of a slot is never formed inside this block.
// All interface outputs come straight from flops.
module subbytes_seq #(
    parameter int NBYTES = 16,
    parameter int MASKED = 1
) (
    input  logic           clk,
    input  logic           rst,
    subbytes_seq_if.master bus
);

    localparam int            IW       = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam bit            MASK_EN  = (MASKED != 0);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One Galois step of the mask generator; a non-zero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // Control state.
    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          gap_q, gap_d;

    // Registered outputs.
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          sbox_req_q, sbox_req_d;
    logic [7:0]    sbox_data_q, sbox_data_d;
    logic [7:0]    sbox_mask_in_q, sbox_mask_in_d;
    logic [7:0]    sbox_mask_out_q, sbox_mask_out_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [7:0]    out_mask_q, out_mask_d;

    // Slot storage: one data share and one mask share per byte. Not reset;
    // every path that presents a slot only does so after it was rewritten.
    logic [7:0]    slot_data_q [NBYTES];
    logic [7:0]    slot_mask_q [NBYTES];
    logic          slot_wr_s;
    logic [7:0]    slot_data_d;
    logic [7:0]    slot_mask_d;

    // Handshake qualifiers; a stray ack without an outstanding request is dropped.
    logic          load_acc_s;
    logic          ack_acc_s;
    logic          out_acc_s;

    // Accepted-transfer strobes for the three handshakes.
    always_comb begin
        load_acc_s = bus.in_valid && in_ready_q;
        ack_acc_s  = bus.sbox_ack && sbox_req_q;
        out_acc_s  = out_valid_q && bus.out_ready;
    end

    // Next-state, byte index, LFSR and slot-write decode for LOAD/RUN/DRAIN.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        gap_d       = 1'b0;
        slot_wr_s   = 1'b0;
        slot_data_d = 8'h00;
        slot_mask_d = 8'h00;
        case (state_q)
            ST_LOAD: begin
                if (load_acc_s) begin
                    slot_wr_s   = 1'b1;
                    slot_data_d = bus.in_data;
                    slot_mask_d = MASK_EN ? bus.in_mask : 8'h00;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IW{1'b0}};
                        state_d = ST_RUN;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RUN: begin
                if (ack_acc_s) begin
                    // Result comes back masked by the mask we handed out.
                    slot_wr_s   = 1'b1;
                    slot_data_d = bus.sbox_res;
                    slot_mask_d = sbox_mask_out_q;
                    lfsr_d      = MASK_EN ? lfsr_step(lfsr_q) : lfsr_q;
                    gap_d       = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IW{1'b0}};
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    gap_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (out_acc_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IW{1'b0}};
                        state_d = ST_LOAD;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = {IW{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // ports themselves are plain flops. Shares are zero whenever not presented.
    always_comb begin
        in_ready_d      = (state_d == ST_LOAD);
        busy_d          = (state_d != ST_LOAD);
        sbox_req_d      = (state_d == ST_RUN) && !gap_d;
        out_valid_d     = (state_d == ST_DRAIN);
        sbox_data_d     = 8'h00;
        sbox_mask_in_d  = 8'h00;
        sbox_mask_out_d = 8'h00;
        out_data_d      = 8'h00;
        out_mask_d      = 8'h00;
        if (sbox_req_d) begin
            sbox_data_d     = slot_data_q[idx_d];
            sbox_mask_in_d  = MASK_EN ? slot_mask_q[idx_d] : 8'h00;
            sbox_mask_out_d = MASK_EN ? lfsr_d : 8'h00;
        end else begin
            sbox_data_d     = 8'h00;
        end
        if (out_valid_d) begin
            out_data_d = slot_data_q[idx_d];
            out_mask_d = MASK_EN ? slot_mask_q[idx_d] : 8'h00;
        end else begin
            out_data_d = 8'h00;
        end
    end

    // Control and output registers; reset abandons any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_LOAD;
            idx_q           <= {IW{1'b0}};
            lfsr_q          <= 8'h01;
            gap_q           <= 1'b0;
            in_ready_q      <= 1'b1;
            busy_q          <= 1'b0;
            sbox_req_q      <= 1'b0;
            sbox_data_q     <= 8'h00;
            sbox_mask_in_q  <= 8'h00;
            sbox_mask_out_q <= 8'h00;
            out_valid_q     <= 1'b0;
            out_data_q      <= 8'h00;
            out_mask_q      <= 8'h00;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            lfsr_q          <= lfsr_d;
            gap_q           <= gap_d;
            in_ready_q      <= in_ready_d;
            busy_q          <= busy_d;
            sbox_req_q      <= sbox_req_d;
            sbox_data_q     <= sbox_data_d;
            sbox_mask_in_q  <= sbox_mask_in_d;
            sbox_mask_out_q <= sbox_mask_out_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_mask_q      <= out_mask_d;
        end
    end

    // Slot write port, shared by input loading and S-box write-back.
    always_ff @(posedge clk) begin
        if (slot_wr_s) begin
            slot_data_q[idx_q] <= slot_data_d;
            slot_mask_q[idx_q] <= slot_mask_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.busy          = busy_q;
    assign bus.sbox_req      = sbox_req_q;
    assign bus.sbox_data     = sbox_data_q;
    assign bus.sbox_mask_in  = sbox_mask_in_q;
    assign bus.sbox_mask_out = sbox_mask_out_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_mask      = out_mask_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Scoreboard bench for subbytes_seq: an unmasked instance (dut0) and a masked
// instance (dut1), each with its own S-box responder and output monitor.
`timescale 1ns/1ps
module tb_subbytes_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus (index 0 = unmasked, 1 = masked).
    logic [1:0] rst_v       = 2'b11;
    logic [1:0] in_valid_v  = 2'b00;
    logic [1:0] ack_v       = 2'b00;
    logic [1:0] out_ready_v = 2'b11;
    logic [7:0] in_data_v [2];
    logic [7:0] in_mask_v [2];
    logic [7:0] res_v     [2];

    // Per-instance observed outputs.
    logic [1:0] in_ready_w, req_w, ov_w, busy_w;
    logic [7:0] sdata_w [2];
    logic [7:0] smi_w   [2];
    logic [7:0] smo_w   [2];
    logic [7:0] od_w    [2];
    logic [7:0] om_w    [2];

    subbytes_seq_if if0 ();
    subbytes_seq_if if1 ();

    subbytes_seq #(.NBYTES(16), .MASKED(0)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0.master));
    subbytes_seq #(.NBYTES(16), .MASKED(1)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1.master));

    assign if0.in_valid = in_valid_v[0];  assign if1.in_valid = in_valid_v[1];
    assign if0.in_data  = in_data_v[0];   assign if1.in_data  = in_data_v[1];
    assign if0.in_mask  = in_mask_v[0];   assign if1.in_mask  = in_mask_v[1];
    assign if0.sbox_ack = ack_v[0];       assign if1.sbox_ack = ack_v[1];
    assign if0.sbox_res = res_v[0];       assign if1.sbox_res = res_v[1];
    assign if0.out_ready = out_ready_v[0]; assign if1.out_ready = out_ready_v[1];

    assign in_ready_w = {if1.in_ready, if0.in_ready};
    assign req_w      = {if1.sbox_req, if0.sbox_req};
    assign ov_w       = {if1.out_valid, if0.out_valid};
    assign busy_w     = {if1.busy, if0.busy};
    assign sdata_w[0] = if0.sbox_data;     assign sdata_w[1] = if1.sbox_data;
    assign smi_w[0]   = if0.sbox_mask_in;  assign smi_w[1]   = if1.sbox_mask_in;
    assign smo_w[0]   = if0.sbox_mask_out; assign smo_w[1]   = if1.sbox_mask_out;
    assign od_w[0]    = if0.out_data;      assign od_w[1]    = if1.out_data;
    assign om_w[0]    = if0.out_mask;      assign om_w[1]    = if1.out_mask;

    // AES S-box entries for inputs 00..0F.
    logic [7:0] sbox16 [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                                8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues: {unmasked result, expected out_mask}.
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [7:0]  lfsr_m [2];
    int          ack_lat [2];
    bit          spur [2];
    int          acks [2];
    int          outs [2];
    logic [7:0]  cap [3];
    int          cap_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // S-box core model with configurable latency and optional stray acks.
    task automatic responder(input int s);
        int         cnt = 0;
        int         gap = -1;
        logic       prev_req = 1'b0;
        logic [23:0] held = 24'h0;
        logic [7:0] u;
        forever begin
            @(posedge clk); #1;
            if (rst_v[s]) begin
                ack_v[s] = 1'b0; cnt = 0; gap = -1; prev_req = 1'b0;
            end else if (req_w[s]) begin
                if (!prev_req) begin
                    held = {sdata_w[s], smi_w[s], smo_w[s]};
                    if (gap >= 0) chk("req_gap", 64'(gap), 64'd1);
                    cnt = 0;
                end else begin
                    chk("req_hold", {40'h0, sdata_w[s], smi_w[s], smo_w[s]}, {40'h0, held});
                end
                if (cnt >= ack_lat[s]) begin
                    u = sdata_w[s] ^ smi_w[s];
                    res_v[s] = sbox16[u[3:0]] ^ smo_w[s];
                    ack_v[s] = 1'b1;
                    acks[s]++;
                end else begin
                    ack_v[s] = 1'b0;
                    cnt++;
                end
                prev_req = 1'b1;
            end else begin
                ack_v[s] = spur[s];
                res_v[s] = 8'hFF;
                if (busy_w[s] && !ov_w[s]) begin
                    if (prev_req) gap = 0;
                    if (gap >= 0) gap++;
                end else begin
                    gap = -1;
                end
                prev_req = 1'b0;
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted output byte.
    task automatic monitor(input int s);
        logic        stall = 1'b0;
        logic [15:0] held = 16'h0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_v[s]) begin
                stall = 1'b0;
            end else if (ov_w[s]) begin
                if (stall) chk("out_hold", {48'h0, od_w[s], om_w[s]}, {48'h0, held});
                chk("in_ready_drain", 64'(in_ready_w[s]), 64'd0);
                if (out_ready_v[s]) begin
                    if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("queue_empty", 64'd1, 64'd0);
                    end else begin
                        e = (s == 0) ? q0.pop_front() : q1.pop_front();
                        chk("out_value", 64'(od_w[s] ^ om_w[s]), 64'(e[15:8]));
                        chk("out_mask", 64'(om_w[s]), 64'(e[7:0]));
                    end
                    if (s == 1 && cap_n < 3) cap[cap_n] = om_w[s];
                    if (s == 1) cap_n++;
                    outs[s]++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = {od_w[s], om_w[s]};
                end
            end
        end
    endtask

    // Loads one 16-byte block of i^dx with mask share mk; starts at posedge+1.
    task automatic load_block(input int s, input logic [7:0] dx, input logic [7:0] mk);
        int guard;
        logic [7:0] iv;
        for (int i = 0; i < 16; i++) begin
            iv = i[7:0];
            in_valid_v[s] = 1'b1;
            in_data_v[s]  = iv ^ dx;
            in_mask_v[s]  = mk;
            guard = 0;
            while (!in_ready_w[s] && guard < 200) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= 200) chk("load_timeout", 64'd1, 64'd0);
            if (s == 0) begin
                q0.push_back({sbox16[iv[3:0]], 8'h00});
            end else begin
                q1.push_back({sbox16[iv[3:0]], lfsr_m[1]});
                lfsr_m[1] = lstep(lfsr_m[1]);
            end
            @(posedge clk); #1;
        end
        in_valid_v[s] = 1'b0;
    endtask

    task automatic wait_outs(input int s, input int n);
        int guard = 0;
        while (outs[s] < n && guard < 2000) begin
            @(posedge clk); #1; guard++;
        end
        chk("drain_count", 64'(outs[s]), 64'(n));
    endtask

    task automatic chk_reset(input int s, input string name);
        chk({name, "_ctl"}, {60'h0, in_ready_w[s], req_w[s], ov_w[s], busy_w[s]}, {60'h0, 4'b1000});
        chk({name, "_bus"}, {24'h0, od_w[s], om_w[s], sdata_w[s], smi_w[s], smo_w[s]}, 64'h0);
    endtask

    initial begin
        fork
            responder(0);
            responder(1);
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data_v[0] = 8'h00; in_data_v[1] = 8'h00;
        in_mask_v[0] = 8'h00; in_mask_v[1] = 8'h00;
        res_v[0] = 8'h00; res_v[1] = 8'h00;
        lfsr_m[0] = 8'h01; lfsr_m[1] = 8'h01;
        ack_lat[0] = 0; ack_lat[1] = 0;
        spur[0] = 1'b0; spur[1] = 1'b0;
        acks[0] = 0; acks[1] = 0;
        outs[0] = 0; outs[1] = 0;

        // Reset values on both instances.
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0, "reset0");
        chk_reset(1, "reset1");
        rst_v = 2'b00;
        @(posedge clk); #1;

        // Unmasked block 00..0F, zero-latency S-box, in_mask must be ignored.
        load_block(0, 8'h00, 8'hA5);
        wait_outs(0, 16);

        // Masked block with mask 42, zero-latency S-box.
        cap_n = 0; outs[1] = 0;
        load_block(1, 8'h42, 8'h42);
        wait_outs(1, 16);
        chk("mask_b0", 64'(cap[0]), 64'h01);
        chk("mask_b1", 64'(cap[1]), 64'hB8);
        chk("mask_b2", 64'(cap[2]), 64'h5C);

        // Delayed acks, stray acks in LOAD and gaps, consumer stall in DRAIN.
        ack_lat[1] = 3; spur[1] = 1'b1; out_ready_v[1] = 1'b0; outs[1] = 0;
        load_block(1, 8'h3C, 8'h3C);
        for (int g = 0; g < 400 && !ov_w[1]; g++) begin
            @(posedge clk); #1;
        end
        chk("drain_reached", 64'(ov_w[1]), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready_v[1] = 1'b1;
        wait_outs(1, 16);

        // Reset after seven acks in RUN; the block is abandoned.
        spur[1] = 1'b0; acks[1] = 0;
        load_block(1, 8'h11, 8'h11);
        for (int g = 0; g < 400 && acks[1] < 7; g++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("busy_before_rst", 64'(busy_w[1]), 64'd1);
        rst_v[1] = 1'b1;
        #1;
        chk_reset(1, "rst_mid_run");
        q1.delete();
        lfsr_m[1] = 8'h01;
        repeat (2) begin
            @(posedge clk); #1;
        end
        spur[1] = 1'b1;
        rst_v[1] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("idle_after_rst", {62'h0, in_ready_w[1], busy_w[1]}, {62'h0, 2'b10});

        // Fresh block after reset; LFSR restarts at 01.
        ack_lat[1] = 0; cap_n = 0; outs[1] = 0;
        load_block(1, 8'h42, 8'h42);
        wait_outs(1, 16);
        chk("mask_after_rst", 64'(cap[0]), 64'h01);
        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
